// File: rtl/fifo_ctrl_pkg.sv
// Shared transmission-layer constants for the FIFO controller: FSM state
// encodings and default threshold helpers.
package fifo_ctrl_pkg;

  localparam logic [1:0] ST_EMPTY  = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_FULL   = 2'd2;

  localparam int AE_DEFAULT_VAL = 1;

  // The almost-full default depends on depth, so it is derived from the pointer width.
  function automatic int af_default(input int addr_width);
    return (1 << addr_width) - 1;
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Enable-gated wrapping address counter; the natural binary overflow
// provides the modulo-depth wrap.
module fifo_ptr #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_ptr
);

  logic [WIDTH-1:0] r_ptr;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ptr <= '0;
    end else if (i_en) begin
      r_ptr <= r_ptr + 1'b1;
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/fifo_ctrl.sv
// FIFO controller: pointers, occupancy, EMPTY/ACTIVE/FULL FSM and threshold flags.
// Optional sticky error flags are built in when FIFO_CTRL_ERR_EN is defined.
module fifo_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 2,
  parameter int AF_DEFAULT = af_default(ADDR_WIDTH),
  parameter int AE_DEFAULT = AE_DEFAULT_VAL
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [ADDR_WIDTH:0]   thr_af,
  input  logic [ADDR_WIDTH:0]   thr_ae,
  input  logic                  thr_load,
  output logic                  mem_wr_enable,
  output logic                  mem_rd_enable,
  output logic [ADDR_WIDTH-1:0] mem_wr_ptr,
  output logic [ADDR_WIDTH-1:0] mem_rd_ptr,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  err_overflow,
  output logic                  err_underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LP_DEPTH = DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] LP_AF    = AF_DEFAULT[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] LP_AE    = AE_DEFAULT[ADDR_WIDTH:0];

  // The data path lives outside this block; only guard against a nonsensical width.
  if (DATA_WIDTH < 1) begin : g_bad_data_width
    $error("fifo_ctrl: DATA_WIDTH must be at least 1");
  end

  logic [1:0]          r_state;
  logic [1:0]          w_state_next;
  logic [ADDR_WIDTH:0] r_count;
  logic [ADDR_WIDTH:0] w_count_next;
  logic [ADDR_WIDTH:0] r_thr_af;
  logic [ADDR_WIDTH:0] r_thr_ae;
  logic                r_af;
  logic                r_ae;
  logic                w_push_acc;
  logic                w_pop_acc;

  // A pop in EMPTY is refused, so push+pop there degrades to push only.
  assign w_pop_acc  = reset & pop & (r_state != ST_EMPTY);
  assign w_push_acc = reset & push & ((r_state != ST_FULL) | w_pop_acc);

  assign mem_wr_enable = w_push_acc;
  assign mem_rd_enable = w_pop_acc;

  always_comb begin
    w_count_next = r_count;
    case ({w_push_acc, w_pop_acc})
      2'b10:   w_count_next = r_count + 1'b1;
      2'b01:   w_count_next = r_count - 1'b1;
      default: w_count_next = r_count;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_EMPTY: begin
        if (w_push_acc) w_state_next = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (w_count_next == LP_DEPTH) w_state_next = ST_FULL;
        else if (w_count_next == '0)  w_state_next = ST_EMPTY;
      end
      ST_FULL: begin
        if (w_pop_acc && !w_push_acc) w_state_next = ST_ACTIVE;
      end
      default: w_state_next = ST_EMPTY;
    endcase
  end

  // Flags compare against the thresholds held before this edge, so a load
  // only influences them from the next cycle on.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= ST_EMPTY;
      r_count  <= '0;
      r_thr_af <= LP_AF;
      r_thr_ae <= LP_AE;
      r_af     <= 1'b0;
      r_ae     <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
      r_af    <= (w_count_next >= r_thr_af);
      r_ae    <= (w_count_next <= r_thr_ae);
      if (thr_load) begin
        r_thr_af <= thr_af;
        r_thr_ae <= thr_ae;
      end
    end
  end

  assign empty        = (r_state == ST_EMPTY);
  assign full         = (r_state == ST_FULL);
  assign almost_full  = r_af;
  assign almost_empty = r_ae;
  assign count        = r_count;

`ifdef FIFO_CTRL_ERR_EN
  logic r_err_ovf;
  logic r_err_unf;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_err_ovf <= 1'b0;
      r_err_unf <= 1'b0;
    end else begin
      if (push && !w_push_acc) r_err_ovf <= 1'b1;
      if (pop && !w_pop_acc)   r_err_unf <= 1'b1;
    end
  end

  assign err_overflow  = r_err_ovf;
  assign err_underflow = r_err_unf;
`else
  assign err_overflow  = 1'b0;
  assign err_underflow = 1'b0;
`endif

  fifo_ptr #(.WIDTH(ADDR_WIDTH)) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .i_en  (w_push_acc),
    .o_ptr (mem_wr_ptr)
  );

  fifo_ptr #(.WIDTH(ADDR_WIDTH)) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .i_en  (w_pop_acc),
    .o_ptr (mem_rd_ptr)
  );

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl (D=4, AF=3, AE=1): directed vector table,
// hand-written corner sequences and random traffic against an occupancy model.
module tb_fifo_ctrl;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset, push, pop, thr_load;
  logic [2:0] thr_af, thr_ae;
  logic       mem_wr_enable, mem_rd_enable;
  logic [1:0] mem_wr_ptr, mem_rd_ptr;
  logic       full, empty, almost_full, almost_empty;
  logic [2:0] count;
  logic       err_overflow, err_underflow;

  int nChecks = 0;
  int nFails  = 0;

  // Reference model state: plain integer occupancy and indices.
  int  mCnt, mWr, mRd, mTaf, mTae;
  bit  mAf, mAe, mOvf, mUnf;

  fifo_ctrl dut (
    .clk(clk), .reset(reset), .push(push), .pop(pop),
    .thr_af(thr_af), .thr_ae(thr_ae), .thr_load(thr_load),
    .mem_wr_enable(mem_wr_enable), .mem_rd_enable(mem_rd_enable),
    .mem_wr_ptr(mem_wr_ptr), .mem_rd_ptr(mem_rd_ptr),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .err_overflow(err_overflow), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit push;
    bit pop;
    bit rst;
    bit expWr;
    bit expRd;
    int expCnt;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(bit p, bit q, bit r, bit w, bit rd, int c);
    vec_t v;
    v.push = p; v.pop = q; v.rst = r; v.expWr = w; v.expRd = rd; v.expCnt = c;
    return v;
  endfunction

  task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle: inputs at negedge, compare everything before the edge, advance model after it.
  task automatic applyStimulus(input bit p, input bit q, input bit r, input bit l,
                               input int af, input int ae,
                               output bit wrSeen, output bit rdSeen);
    bit popOk, pushOk;
    @(negedge clk);
    push = p; pop = q; reset = ~r; thr_load = l;
    thr_af = 3'(af); thr_ae = 3'(ae);
    #1;
    popOk  = !r && q && (mCnt > 0);
    pushOk = !r && p && (mCnt < DEPTH || popOk);
    wrSeen = mem_wr_enable;
    rdSeen = mem_rd_enable;
    checkOutput("wr_enable", 32'(mem_wr_enable), 32'(pushOk));
    checkOutput("rd_enable", 32'(mem_rd_enable), 32'(popOk));
    checkOutput("wr_ptr", 32'(mem_wr_ptr), 32'(mWr));
    checkOutput("rd_ptr", 32'(mem_rd_ptr), 32'(mRd));
    checkOutput("count", 32'(count), 32'(mCnt));
    checkOutput("full", 32'(full), 32'(mCnt == DEPTH));
    checkOutput("empty", 32'(empty), 32'(mCnt == 0));
    checkOutput("almost_full", 32'(almost_full), 32'(mAf));
    checkOutput("almost_empty", 32'(almost_empty), 32'(mAe));
    checkOutput("err_overflow", 32'(err_overflow), 32'(mOvf));
    checkOutput("err_underflow", 32'(err_underflow), 32'(mUnf));
    @(posedge clk);
    if (r) begin
      mCnt = 0; mWr = 0; mRd = 0; mTaf = DEPTH - 1; mTae = 1;
      mAf = 0; mAe = 1; mOvf = 0; mUnf = 0;
    end else begin
`ifdef FIFO_CTRL_ERR_EN
      if (p && !pushOk) mOvf = 1;
      if (q && !popOk)  mUnf = 1;
`endif
      if (pushOk) begin mCnt++; mWr = (mWr + 1) % DEPTH; end
      if (popOk)  begin mCnt--; mRd = (mRd + 1) % DEPTH; end
      mAf = (mCnt >= mTaf);
      mAe = (mCnt <= mTae);
      if (l) begin mTaf = af; mTae = ae; end
    end
  endtask

  initial begin
    bit w, rd;
    push = 0; pop = 0; thr_load = 0; thr_af = 0; thr_ae = 0; reset = 1'b0;
    repeat (2) @(posedge clk);
    mCnt = 0; mWr = 0; mRd = 0; mTaf = DEPTH - 1; mTae = 1;
    mAf = 0; mAe = 1; mOvf = 0; mUnf = 0;

    vecs[0]  = mk(1, 0, 1, 0, 0, 0);
    vecs[1]  = mk(1, 0, 0, 1, 0, 1);
    vecs[2]  = mk(1, 0, 0, 1, 0, 2);
    vecs[3]  = mk(1, 0, 0, 1, 0, 3);
    vecs[4]  = mk(1, 0, 0, 1, 0, 4);
    vecs[5]  = mk(1, 0, 0, 0, 0, 4);
    vecs[6]  = mk(1, 1, 0, 1, 1, 4);
    vecs[7]  = mk(0, 1, 0, 0, 1, 3);
    vecs[8]  = mk(0, 1, 0, 0, 1, 2);
    vecs[9]  = mk(0, 1, 0, 0, 1, 1);
    vecs[10] = mk(0, 1, 0, 0, 1, 0);
    vecs[11] = mk(0, 1, 0, 0, 0, 0);
    vecs[12] = mk(1, 1, 0, 1, 0, 1);
    vecs[13] = mk(0, 1, 0, 0, 1, 0);

    $display("[TB] directed vector table");
    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].push, vecs[i].pop, vecs[i].rst, 1'b0, 0, 0, w, rd);
      checkOutput($sformatf("vec%0d_wr", i), 32'(w), 32'(vecs[i].expWr));
      checkOutput($sformatf("vec%0d_rd", i), 32'(rd), 32'(vecs[i].expRd));
      #1;
      checkOutput($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].expCnt));
    end

    $display("[TB] mid-stream reset");
    applyStimulus(0, 1, 0, 0, 0, 0, w, rd);
    applyStimulus(1, 0, 0, 0, 0, 0, w, rd);
    applyStimulus(1, 0, 0, 0, 0, 0, w, rd);
    applyStimulus(1, 1, 1, 0, 0, 0, w, rd);
    #1;
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_empty", 32'(empty), 32'd1);
    checkOutput("rst_wr_ptr", 32'(mem_wr_ptr), 32'd0);
    checkOutput("rst_rd_ptr", 32'(mem_rd_ptr), 32'd0);
    checkOutput("rst_ovf", 32'(err_overflow), 32'd0);
    checkOutput("rst_unf", 32'(err_underflow), 32'd0);

    $display("[TB] threshold load at count 2");
    applyStimulus(1, 0, 0, 0, 0, 0, w, rd);
    applyStimulus(1, 0, 0, 0, 0, 0, w, rd);
    applyStimulus(0, 0, 0, 1, 2, 1, w, rd);
    #1;
    checkOutput("load_af_same_cycle", 32'(almost_full), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, w, rd);
    #1;
    checkOutput("load_af_next_cycle", 32'(almost_full), 32'd1);

    $display("[TB] random traffic");
    for (int i = 0; i < 600; i++) begin
      int pushBias;
      pushBias = ((i / 40) % 2 == 0) ? 75 : 25;
      applyStimulus(($urandom_range(0, 99) < pushBias), ($urandom_range(0, 99) >= pushBias),
                    ($urandom_range(0, 79) == 0), ($urandom_range(0, 19) == 0),
                    int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), w, rd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/fifo_ctrl.md
FIFO_CTRL -- requirements
Module: fifo_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 6, word width of the controlled storage (pass-through only).
REQ-002 SHALL have parameter ADDR_WIDTH, default 2, pointer width; depth D = 2**ADDR_WIDTH.
REQ-003 SHALL have parameter AF_DEFAULT, default D-1, almost-full threshold loaded at reset.
REQ-004 SHALL have parameter AE_DEFAULT, default 1, almost-empty threshold loaded at reset.
REQ-005 SHALL provide: clk  input  1  clock; reset  input  1  synchronous, active-low reset.
REQ-006 SHALL provide: push  input  1  write request; pop  input  1  read request.
REQ-007 SHALL provide: thr_af, thr_ae  input  ADDR_WIDTH+1 each  threshold values; thr_load  input  1  latch both thresholds.
REQ-008 SHALL provide: mem_wr_enable, mem_rd_enable  output  1 each  storage write/read strobes.
REQ-009 SHALL provide: mem_wr_ptr, mem_rd_ptr  output  ADDR_WIDTH each  storage addresses.
REQ-010 SHALL provide: full, empty, almost_full, almost_empty  output  1 each  registered status flags.
REQ-011 SHALL provide: count  output  ADDR_WIDTH+1  current occupancy, 0..D.
REQ-012 SHALL provide: err_overflow, err_underflow  output  1 each  sticky error flags.

Function
REQ-013 SHALL accept push when push=1 and (full=0 or accepted pop this cycle); accepted push drives mem_wr_enable=1 combinationally and increments wr_ptr at next edge.
REQ-014 SHALL accept pop when pop=1 and empty=0; accepted pop drives mem_rd_enable=1 combinationally, read data valid same cycle, rd_ptr increments at next edge.
REQ-015 SHALL never assert mem_wr_enable or mem_rd_enable for a rejected request.
REQ-016 SHALL wrap both pointers from D-1 to 0 modulo D.
REQ-017 SHALL update count: +1 push only, -1 pop only, unchanged for both or neither.
REQ-018 SHALL implement FSM EMPTY/ACTIVE/FULL: EMPTY->ACTIVE on push; ACTIVE->FULL when count reaches D; ACTIVE->EMPTY when count reaches 0; FULL->ACTIVE on pop without push; FULL stays FULL on simultaneous push+pop.
REQ-019 SHALL drive empty=1 iff state EMPTY, full=1 iff state FULL, both registered, no combinational path from push/pop.
REQ-020 SHALL drive almost_full=1 iff next count >= thr_af, almost_empty=1 iff next count <= thr_ae, registered.
REQ-021 SHALL latch thr_af/thr_ae on thr_load=1; a load takes effect for flags from the following cycle.
REQ-022 SHALL treat simultaneous push+pop in EMPTY as push only (no fall-through).

Reset
REQ-023 SHALL on reset=0 at a clk edge set pointers 0, count 0, state EMPTY, empty=1, almost_empty=1, full=0, almost_full=0, thresholds to defaults, error flags 0.
REQ-024 SHALL hold mem_wr_enable=mem_rd_enable=0 while reset=0, ignoring push/pop.
REQ-025 SHALL abandon any in-flight occupancy on mid-operation reset; no state survives.

Configuration
REQ-026 SHALL, with FIFO_CTRL_ERR_EN defined, set err_overflow on push rejected by full and err_underflow on pop rejected by empty, sticky until reset.
REQ-027 SHALL, without FIFO_CTRL_ERR_EN, tie err_overflow/err_underflow to 0 and silently drop rejected requests.

Structure
REQ-028 SHALL take FSM state encodings and default threshold constants from the shared transmission-layer package.
REQ-029 SHALL use one sub-module, fifo_ptr, instantiated twice (write, read): enable-gated wrapping counter.

Verification (D=4, AF=3, AE=1)
REQ-030 SHALL test: reset then 4 pushes -> wr_ptr 0,1,2,3,0; count 4; full=1 after 4th edge; almost_full=1 after 3rd.
REQ-031 SHALL test: from full, 5th push -> mem_wr_enable=0, count stays 4, err_overflow=1 (ERR_EN).
REQ-032 SHALL test: pop from empty -> mem_rd_enable=0, count 0, err_underflow=1 (ERR_EN), 0 without.
REQ-033 SHALL test: full + simultaneous push/pop -> both strobes 1, count 4, state FULL, both pointers advance.
REQ-034 SHALL test: count 2, assert reset mid-stream -> next edge count 0, empty=1, pointers 0, errors cleared.
REQ-035 SHALL test: thr_load with thr_af=2 at count 2 -> almost_full=1 one cycle after load.
